// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with a 2-entry IF/ID FIFO and redirect handling
module instr_fetch_unit #(
    parameter logic [8:0]  RESET_PC  = 9'h000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [8:0]  redirect_pc,
    output logic        imem_req,
    output logic [8:0]  imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [8:0]  if_id_pc,
    output logic [31:0] if_id_instr
);

    logic [8:0]  pc_q;
    logic [8:0]  saved_addr;
    logic        outstanding;
    logic        discard;
    logic [8:0]  fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic        grant;
    logic [1:0]  count_after;
    logic [8:0]  redirect_target;

    assign redirect_target = redirect_pc & 9'h1FC;

    // A response is kept only if it belongs to the live request; stray data after reset is ignored.
    assign push = reset_n && !redirect && imem_rvalid && outstanding && !discard;
    assign pop  = reset_n && !redirect && (count != 2'd0) && !stall;

    assign count_after = count + {1'b0, push} - {1'b0, pop};

    assign imem_req  = reset_n && !redirect && (!outstanding || imem_rvalid) && (count_after <= 2'd1);
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    assign if_id_valid = (count != 2'd0);
    assign if_id_pc    = if_id_valid ? fifo_pc[rd_ptr]    : 9'h000;
    assign if_id_instr = if_id_valid ? fifo_instr[rd_ptr] : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            saved_addr  <= 9'h000;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (redirect) begin
            pc_q   <= redirect_target;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            // The in-flight response, if it has not returned yet, must be thrown away on arrival.
            if (outstanding && !imem_rvalid) begin
                discard <= 1'b1;
            end
            if (imem_rvalid) begin
                outstanding <= 1'b0;
            end
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                discard     <= 1'b0;
                saved_addr  <= pc_q;
                pc_q        <= pc_q + 9'd4;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= saved_addr;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && count == 2'd2));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [8:0]  RESET_PC  = 9'h000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [8:0]  if_id_pc;
    logic [31:0] if_id_instr;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    typedef struct packed {
        logic [8:0]  pc;
        logic [31:0] instr;
    } entry_t;

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    // Program-order view of what decode should see, plus the memory's single in-flight request.
    entry_t     expq[$];
    logic [8:0] m_pc;
    bit         mem_out;
    bit         mem_stale;
    bit         mem_orphan;
    int         mem_delay;
    logic [8:0] mem_addr;

    function automatic logic [31:0] word_at(input logic [8:0] a);
        return {a[7:0], ~a[7:0], 7'h00, a} ^ 32'h5A3C_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit stl, input bit rdr, input logic [8:0] rpc,
                        input bit g, input int lat);
        bit         rv;
        bit         dut_out;
        bit         push;
        bit         pop;
        bit         exp_req;
        int         occ;
        entry_t     e;
        @(negedge clk);
        reset_n     = rst_n;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_gnt    = g;
        rv          = 1'b0;
        imem_rdata  = $urandom;
        if (rst_n && mem_out) begin
            if (mem_orphan) begin
                rv = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end else begin
                mem_delay--;
                rv = (mem_delay <= 0);
                if (rv) imem_rdata = word_at(mem_addr);
            end
        end
        imem_rvalid = rv;
        #1;

        dut_out = mem_out && !mem_orphan;
        push    = rst_n && !rdr && rv && dut_out && !mem_stale;
        pop     = rst_n && !rdr && (expq.size() > 0) && !stl;
        occ     = expq.size() + int'(push) - int'(pop);
        exp_req = rst_n && !rdr && (!dut_out || rv) && (occ <= 1);

        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, expq.size() > 0});
        check("if_id_pc", {23'd0, if_id_pc}, expq.size() > 0 ? {23'd0, expq[0].pc} : 32'd0);
        check("if_id_instr", if_id_instr, expq.size() > 0 ? expq[0].instr : NOP_INSTR);
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", {23'd0, imem_addr}, {23'd0, m_pc});

        if (rv) begin
            mem_out    = 1'b0;
            mem_orphan = 1'b0;
        end
        if (!rst_n) begin
            expq.delete();
            m_pc = RESET_PC;
            if (mem_out) mem_orphan = 1'b1;
        end else if (rdr) begin
            expq.delete();
            m_pc = {rpc[8:2], 2'b00};
            if (mem_out) mem_stale = 1'b1;
        end else begin
            if (pop) begin
                void'(expq.pop_front());
                delivered++;
            end
            if (push) begin
                e.pc    = mem_addr;
                e.instr = word_at(mem_addr);
                expq.push_back(e);
            end
            if (exp_req && g) begin
                mem_out    = 1'b1;
                mem_stale  = 1'b0;
                mem_orphan = 1'b0;
                mem_addr   = m_pc;
                mem_delay  = lat;
                m_pc       = m_pc + 9'd4;
            end
        end
    endtask

    initial begin
        int rst_hold;
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 9'h000;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        m_pc        = RESET_PC;
        mem_out     = 1'b0;
        mem_stale   = 1'b0;
        mem_orphan  = 1'b0;
        mem_delay   = 0;
        mem_addr    = 9'h000;
        repeat (2) @(posedge clk);

        repeat (2) step(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        // Streaming from reset with 1-cycle memory.
        repeat (8) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        // Decode stall holds IF/ID and lets the FIFO fill.
        repeat (5) step(1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        // Redirect while a slow request is still in flight.
        step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 3);
        step(1'b1, 1'b0, 1'b1, 9'h0A7, 1'b1, 1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        // Redirect coinciding with returning data, then run across the 1FC->000 wrap.
        step(1'b1, 1'b0, 1'b1, 9'h1F0, 1'b1, 1);
        repeat (8) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        // Grant withheld for three cycles.
        repeat (3) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        // Reset in the middle of a slow request; its response arrives after release.
        step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 3);
        repeat (2) step(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 1);

        rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            bit rd;
            if (rst_hold == 0 && $urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 2);
            rs = (rst_hold == 0);
            if (rst_hold > 0) rst_hold--;
            rd = rs && ($urandom_range(0, 29) == 0);
            step(rs, $urandom_range(0, 3) == 0, rd, 9'($urandom), $urandom_range(0, 3) != 0,
                 int'($urandom_range(1, 3)));
        end

        check("delivered_progress", {31'd0, delivered > 500}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 9'h000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000013, driven on if_id_instr when no instruction is valid.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  hazard stall from decode; holds the IF/ID output.
REQ-006 redirect  input  1  taken branch or jump from execute.
REQ-007 redirect_pc  input  9  target byte address for redirect.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  9  request byte address.
REQ-010 imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  read data valid, one or more cycles after grant.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 if_id_valid  output  1  if_id_pc and if_id_instr hold a valid instruction.
REQ-014 if_id_pc  output  9  Curr_Pc field of the IF/ID register.
REQ-015 if_id_instr  output  32  Curr_Instr field of the IF/ID register.

Function
REQ-016 The block SHALL contain a 9-bit fetch PC, a 2-entry FIFO of {pc[8:0], instr[31:0]}, an outstanding flag, a discard flag, and a saved request address.
REQ-017 The block SHALL allow at most one memory request to be outstanding.
REQ-018 imem_req SHALL assert only when no redirect is present and both of the following hold:
- outstanding==0, or imem_rvalid==1 this cycle;
- FIFO occupancy after this cycle's push and pop is at most 1.
REQ-019 imem_addr SHALL equal the fetch PC whenever imem_req is high.
REQ-020 On imem_req && imem_gnt the block SHALL:
- set outstanding;
- clear discard;
- save the request address;
- advance the PC by 4, modulo 512 (9'h1FC wraps to 9'h000).
REQ-021 On imem_rvalid with discard==0, the block SHALL push {saved address, imem_rdata} into the FIFO; with discard==1 it SHALL drop the data.
REQ-022 imem_rvalid SHALL clear outstanding unless a new grant occurs in the same cycle.
REQ-023 The outputs SHALL be driven combinationally from the FIFO head:
- if_id_valid = FIFO not empty;
- when the FIFO is empty, if_id_pc = 9'h000 and if_id_instr = NOP_INSTR.
REQ-024 The FIFO head SHALL pop when if_id_valid && !stall; push and pop in the same cycle SHALL both take effect.
REQ-025 While stall is high, the outputs SHALL hold their values and fetching SHALL continue until the FIFO is full.
REQ-026 Redirect SHALL have priority over every other event; in the redirect cycle the block SHALL:
- empty the FIFO;
- load the PC with {redirect_pc[8:2], 2'b00};
- set discard if a request is outstanding and imem_rvalid is not high in that cycle;
- suppress imem_req.
REQ-027 Data returned in the same cycle as a redirect SHALL be dropped.
REQ-028 The first request after a redirect SHALL issue in the following cycle once no request is outstanding.
REQ-029 The FIFO SHALL never overflow; push into a full FIFO is an assertion failure.
REQ-030 Latency: with imem_gnt tied high and 1-cycle rvalid, an instruction SHALL appear on if_id_valid in the cycle after its rvalid, and steady-state throughput SHALL be 1 instruction per cycle.

Reset
REQ-031 While reset_n==0 at a clock edge, the block SHALL set:
- PC = RESET_PC;
- FIFO empty;
- outstanding = 0 and discard = 0;
- imem_req = 0.
REQ-032 Reset asserted mid-operation SHALL drop any outstanding response that arrives after reset is released.
REQ-033 The first request, with imem_addr = RESET_PC, SHALL issue in the first cycle with reset_n==1.

Verification
REQ-034 Reset release, gnt=1, rvalid 1 cycle after grant -> requests at addresses 000, 004, 008; if_id_valid rises 2 cycles after release with pc=000, then pc=004, 008 on consecutive cycles.
REQ-035 stall held high for 5 cycles during streaming -> outputs frozen, FIFO fills to 2, imem_req low; stall released -> pcs resume in order with none lost or duplicated.
REQ-036 redirect with redirect_pc=9'h0A7 while a request is outstanding -> FIFO emptied, late response dropped, next request at 0A4, next valid pc=0A4.
REQ-037 redirect in the same cycle as rvalid -> rdata not delivered, next request at the target.
REQ-038 PC at 1FC -> next request wraps to 000.
REQ-039 imem_gnt low for 3 cycles -> imem_req and imem_addr held stable until gnt, with no duplicate FIFO entries.
